down_sample_stream: RTL and testbench
=====================================

DOWN_SAMPLE_STREAM -- requirements
Module: down_sample_stream

Interface
REQ-001 SHALL have parameter DATA_I_WIDTH, default 4: input feature-map columns.
REQ-002 SHALL have parameter DATA_I_HEIGHT, default 4: input feature-map rows.
REQ-003 SHALL have parameter SCALE_FACTOR, default 2: pooling window edge; DATA_I_WIDTH and DATA_I_HEIGHT are integer multiples of it.
REQ-004 SHALL have parameter BITWIDTH, default 8: unsigned pixel width.
REQ-005 SHALL derive DATA_O_WIDTH = DATA_I_WIDTH/SCALE_FACTOR and DATA_O_HEIGHT = DATA_I_HEIGHT/SCALE_FACTOR.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 pix_i_valid  input  1  input pixel valid.
REQ-009 pix_i_ready  output  1  block accepts input pixel.
REQ-010 pix_i  input  BITWIDTH  input pixel, raster order (row-major, column 0 first).
REQ-011 pix_o_valid  output  1  pooled pixel valid.
REQ-012 pix_o_ready  input  1  downstream accepts pooled pixel.
REQ-013 pix_o  output  BITWIDTH  pooled pixel, raster order over the DATA_O_WIDTH x DATA_O_HEIGHT output map.
REQ-014 pix_o_last  output  1  high with the final pooled pixel of a frame.

Function
REQ-015 Input transfer SHALL occur on a clk edge with pix_i_valid and pix_i_ready both high; output transfer likewise with pix_o_valid and pix_o_ready.
REQ-016 Column counter col (0..DATA_I_WIDTH-1) and row counter row (0..DATA_I_HEIGHT-1) SHALL advance only on input transfers; col wraps to 0 and row increments at col = DATA_I_WIDTH-1; both wrap to 0 after the last pixel of a frame.
REQ-017 Block SHALL hold DATA_O_WIDTH partial-result registers acc[k], k = col/SCALE_FACTOR.
REQ-018 On transfer with row%S==0 and col%S==0 (window origin), acc[k] SHALL load pix_i (default) or the zero-extended pix_i (averaging variant).
REQ-019 On any other transfer inside the window, acc[k] SHALL update to combine(acc[k], pix_i): max in the default build, sum in the averaging variant.
REQ-020 On transfer at row%S==S-1 and col%S==S-1 (window close), pix_o SHALL register combine(acc[k], pix_i) (reduced per REQ-032) and pix_o_valid SHALL rise on the following cycle edge; latency one clk from the closing input transfer.
REQ-021 pix_o_last SHALL be set with pix_o when the closing pixel is at row = DATA_I_HEIGHT-1, col = DATA_I_WIDTH-1, and cleared with pix_o_valid.
REQ-022 pix_o, pix_o_valid, pix_o_last SHALL hold stable while pix_o_valid high and pix_o_ready low.
REQ-023 pix_i_ready SHALL equal NOT(pix_o_valid AND NOT pix_o_ready), combinationally.
REQ-024 Simultaneous output transfer and new window close SHALL load the new result with pix_o_valid remaining high (no bubble).
REQ-025 pix_o_valid SHALL clear after an output transfer with no simultaneous window close.
REQ-026 Back-to-back frames SHALL need no idle cycles; frame boundary is implied solely by the counters.
REQ-027 Block SHALL contain no state machine beyond the counters, accumulators and single output register.

Reset
REQ-028 rst_n low SHALL immediately clear col, row, all acc[k], pix_o, pix_o_valid, pix_o_last to 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first transfer after release is pixel (0,0) of a new frame.
REQ-030 Deassertion SHALL be sampled such that the first transfer may occur on the first clk edge after rst_n rises.

Configuration
REQ-031 Macro DOWN_SAMPLE_AVG_EN SHALL select the pooling operator; undefined: max pooling, acc[k] BITWIDTH bits.
REQ-032 Defined: average pooling, acc[k] BITWIDTH+2*log2(SCALE_FACTOR) bits, result = window sum right-shifted by 2*log2(SCALE_FACTOR) (truncating); SCALE_FACTOR SHALL be a power of two in this build.

Verification
REQ-033 Default, 4x4 frame pixels 0..15 raster, pix_o_ready=1 -> pix_o 5,7,13,15; pix_o_last only with 15.
REQ-034 DOWN_SAMPLE_AVG_EN, same stimulus -> pix_o 2,4,10,12; window all 255 -> 255 (no overflow).
REQ-035 pix_o_ready low for 5 cycles after first result -> pix_o held at 5, pix_i_ready low, no input lost, full sequence 5,7,13,15 emitted.
REQ-036 rst_n pulsed after 6 pixels, then fresh frame 0..15 -> outputs exactly 5,7,13,15, no stale data.
REQ-037 Two frames back-to-back (0..15 then 15..0), random pix_i_valid gaps -> 5,7,13,15 then 15,13,7,5, pix_o_last on 4th and 8th outputs.

Source files
------------

// File: rtl/down_sample_stream.sv
// ============================================================================
// down_sample_stream
// ----------------------------------------------------------------------------
// Streaming SCALE_FACTOR x SCALE_FACTOR pooling of a raster-ordered feature
// map. Input pixels arrive row-major with column 0 first. One pooled pixel
// is produced per window, one clock after the window's closing input pixel.
// The pooled pixels leave in raster order over the output map.
//
// Only one input row can be seen at a time. So the block keeps one partial
// result per output column (acc[k]). Each partial result carries a window's
// running value across the rows of that window.
//
// Build option:
//   DOWN_SAMPLE_AVG_EN  undefined -> max pooling. acc[k] is BITWIDTH bits.
//                       defined   -> average pooling. acc[k] holds the
//                                    window sum. The result is that sum
//                                    shifted right by 2*log2(SCALE_FACTOR),
//                                    which truncates. In this build
//                                    SCALE_FACTOR must be a power of two.
//
// Parameters:
//   DATA_I_WIDTH   input columns (a multiple of SCALE_FACTOR)
//   DATA_I_HEIGHT  input rows    (a multiple of SCALE_FACTOR)
//   SCALE_FACTOR   pooling window edge
//   BITWIDTH       unsigned pixel width
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pix_i_valid  input pixel valid
//   pix_i_ready  block accepts an input pixel (combinational from the
//                output stage)
//   pix_i        input pixel
//   pix_o_valid  pooled pixel valid
//   pix_o_ready  downstream accepts the pooled pixel
//   pix_o        pooled pixel
//   pix_o_last   high with the final pooled pixel of a frame
// ============================================================================
module down_sample_stream #(
    parameter int DATA_I_WIDTH  = 4,
    parameter int DATA_I_HEIGHT = 4,
    parameter int SCALE_FACTOR  = 2,
    parameter int BITWIDTH      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_i_valid,
    output logic                pix_i_ready,
    input  logic [BITWIDTH-1:0] pix_i,
    output logic                pix_o_valid,
    input  logic                pix_o_ready,
    output logic [BITWIDTH-1:0] pix_o,
    output logic                pix_o_last
);

    localparam int DATA_O_WIDTH  = DATA_I_WIDTH / SCALE_FACTOR;
    localparam int DATA_O_HEIGHT = DATA_I_HEIGHT / SCALE_FACTOR;

    localparam int LOG2_S = (SCALE_FACTOR > 1) ? $clog2(SCALE_FACTOR) : 0;

`ifdef DOWN_SAMPLE_AVG_EN
    // A full window sum of S*S pixels needs 2*log2(S) extra bits.
    localparam int ACC_W = BITWIDTH + 2 * LOG2_S;
`else
    localparam int ACC_W = BITWIDTH;
`endif

    localparam int COL_W = (DATA_I_WIDTH  > 1) ? $clog2(DATA_I_WIDTH)  : 1;
    localparam int ROW_W = (DATA_I_HEIGHT > 1) ? $clog2(DATA_I_HEIGHT) : 1;
    localparam int K_W   = (DATA_O_WIDTH  > 1) ? $clog2(DATA_O_WIDTH)  : 1;

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [ACC_W-1:0]    acc [DATA_O_WIDTH];

    logic                in_xfer;
    logic                out_xfer;
    logic [K_W-1:0]      acc_idx;
    logic                win_origin;
    logic                win_close;
    logic                col_wrap;
    logic                row_wrap;
    logic                frame_end;
    logic [ACC_W-1:0]    acc_cur;
    logic [ACC_W-1:0]    acc_next;
    logic [BITWIDTH-1:0] result;

    // Input is blocked only while a pooled pixel is stalled downstream.
    // Because of this, a window can never close while the output register
    // is still holding an untaken result.
    assign pix_i_ready = ~(pix_o_valid & ~pix_o_ready);
    assign in_xfer     = pix_i_valid & pix_i_ready;
    assign out_xfer    = pix_o_valid & pix_o_ready;

    // Decode where the current input pixel sits. The decode covers its
    // window, its position inside that window, and whether it ends a row,
    // the frame, or the last output pixel of the frame.
    always_comb begin
        acc_idx    = K_W'(int'(col) / SCALE_FACTOR);
        win_origin = ((int'(col) % SCALE_FACTOR) == 0) &&
                     ((int'(row) % SCALE_FACTOR) == 0);
        win_close  = ((int'(col) % SCALE_FACTOR) == SCALE_FACTOR - 1) &&
                     ((int'(row) % SCALE_FACTOR) == SCALE_FACTOR - 1);
        col_wrap   = (int'(col) == DATA_I_WIDTH - 1);
        row_wrap   = (int'(row) == DATA_I_HEIGHT - 1);
        frame_end  = win_close &&
                     ((int'(col) / SCALE_FACTOR) == DATA_O_WIDTH - 1) &&
                     ((int'(row) / SCALE_FACTOR) == DATA_O_HEIGHT - 1);
    end

    // Merge the incoming pixel into the partial result of its window.
    // At a window origin the old partial result belongs to the previous
    // window, so the pixel alone seeds the new one. The same holds at a
    // pixel that both opens and closes a window.
    always_comb begin
        acc_cur = acc[acc_idx];
`ifdef DOWN_SAMPLE_AVG_EN
        if (win_origin) begin
            acc_next = ACC_W'(pix_i);
        end else begin
            acc_next = acc_cur + ACC_W'(pix_i);
        end
        result = BITWIDTH'(acc_next >> (2 * LOG2_S));
`else
        if (win_origin) begin
            acc_next = pix_i;
        end else begin
            acc_next = (pix_i > acc_cur) ? pix_i : acc_cur;
        end
        result = acc_next;
`endif
    end

    // Raster position counters. They advance only on accepted input
    // pixels, so the frame boundary comes purely from these counters and
    // frames can follow each other with no idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_xfer) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Per-output-column partial results. The slot is also written on the
    // closing pixel. That value is harmless because the next window's
    // origin overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DATA_O_WIDTH; k++) begin
                acc[k] <= '0;
            end
        end else if (in_xfer) begin
            acc[acc_idx] <= acc_next;
        end
    end

    // Single output register. A closing pixel loads a new result. If the
    // previous result is leaving on the same edge, valid simply stays high.
    // Otherwise a taken result clears valid and last together. While the
    // output is stalled, nothing can close, so the register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_o       <= '0;
            pix_o_valid <= 1'b0;
            pix_o_last  <= 1'b0;
        end else if (in_xfer && win_close) begin
            pix_o       <= result;
            pix_o_valid <= 1'b1;
            pix_o_last  <= frame_end;
        end else if (out_xfer) begin
            pix_o_valid <= 1'b0;
            pix_o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_sample_stream.sv
// ============================================================================
// tb_down_sample_stream
// ----------------------------------------------------------------------------
// Scoreboard bench for down_sample_stream with the default 4x4 map, 2x2
// windows and 8-bit pixels. Each directed frame pushes its hand-computed
// pooled pixels into a queue. A monitor pops from that queue and compares on
// every output handshake. Expected values follow DOWN_SAMPLE_AVG_EN when it
// is defined.
// ============================================================================
module tb_down_sample_stream;

    localparam int BW = 8;

    typedef struct packed {
        logic          last;
        logic [BW-1:0] pix;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          pix_i_valid;
    logic          pix_i_ready;
    logic [BW-1:0] pix_i;
    logic          pix_o_valid;
    logic          pix_o_ready;
    logic [BW-1:0] pix_o;
    logic          pix_o_last;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

`ifdef DOWN_SAMPLE_AVG_EN
    int exp_asc[4]  = '{2, 4, 10, 12};
    int exp_desc[4] = '{12, 10, 4, 2};
`else
    int exp_asc[4]  = '{5, 7, 13, 15};
    int exp_desc[4] = '{15, 13, 7, 5};
`endif
    int exp_full[4] = '{255, 255, 255, 255};

    down_sample_stream #(
        .DATA_I_WIDTH (4),
        .DATA_I_HEIGHT(4),
        .SCALE_FACTOR (2),
        .BITWIDTH     (BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_i_valid(pix_i_valid),
        .pix_i_ready(pix_i_ready),
        .pix_i      (pix_i),
        .pix_o_valid(pix_o_valid),
        .pix_o_ready(pix_o_ready),
        .pix_o      (pix_o),
        .pix_o_last (pix_o_last)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. It steps the counters and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Offer one pixel after `gap` idle cycles and hold it until accepted.
    // Acceptance is sampled on the falling edge, where ready is stable.
    task automatic applyStimulus(input logic [BW-1:0] v, input int gap);
        int   waited;
        logic accepted;
        pix_i_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        pix_i_valid = 1'b1;
        pix_i       = v;
        waited      = 0;
        accepted    = 1'b0;
        while (!accepted) begin
            @(negedge clk);
            accepted = pix_i_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!accepted && waited > 100) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL input_accept_timeout: got no accept, required accept of %0d", v);
                break;
            end
        end
        pix_i_valid = 1'b0;
    endtask

    // Queue the four pooled pixels of a frame. The last flag goes on the 4th.
    task automatic pushExpect(input int vals[4]);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.pix  = BW'(vals[i]);
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    // Send one 16-pixel frame. Mode 0 is 0..15, mode 1 is 15..0, and
    // mode 2 is all 255. Gaps are random in 0..max_gap.
    task automatic sendFrame(input int mode, input int max_gap);
        logic [BW-1:0] v;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       v = BW'(i);
                1:       v = BW'(15 - i);
                default: v = 8'd255;
            endcase
            applyStimulus(v, (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        end
    endtask

    // Monitor: every output handshake is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && pix_o_valid && pix_o_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_output: got %0d, required no output", pix_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("pix_o", int'(pix_o), int'(e.pix));
                checkOutput("pix_o_last", int'(pix_o_last), int'(e.last));
            end
        end
    end

    // Stimulus sequence.
    initial begin
        exp_t e;
        int   w;
        rst_n       = 1'b1;
        pix_i_valid = 1'b0;
        pix_i       = '0;
        pix_o_ready = 1'b1;

        // Check the reset state.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_pix_o_valid", int'(pix_o_valid), 0);
        checkOutput("reset_pix_o", int'(pix_o), 0);
        checkOutput("reset_pix_o_last", int'(pix_o_last), 0);
        checkOutput("reset_pix_i_ready", int'(pix_i_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Ascending frame with no gaps.
        $display("[TB] ascending frame");
        pushExpect(exp_asc);
        sendFrame(0, 0);

        // All-255 frame: the result must saturate at 255 without overflow.
        $display("[TB] all-255 frame");
        pushExpect(exp_full);
        sendFrame(2, 0);

        // Downstream stalls for 5 cycles after the first result.
        $display("[TB] output stall");
        pushExpect(exp_asc);
        fork
            sendFrame(0, 0);
            begin
                w = 0;
                do begin
                    @(posedge clk);
                    #1;
                    w++;
                end while (!pix_o_valid && w < 100);
                checkOutput("stall_first_valid", int'(pix_o_valid), 1);
                pix_o_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_pix_o_held", int'(pix_o), exp_asc[0]);
                    checkOutput("stall_valid_held", int'(pix_o_valid), 1);
                    checkOutput("stall_pix_i_ready", int'(pix_i_ready), 0);
                end
                @(posedge clk);
                #1 pix_o_ready = 1'b1;
            end
        join

        // Reset after 6 pixels. Pixel 5 closes window 0 first.
        $display("[TB] mid-frame reset");
        e.pix  = BW'(exp_asc[0]);
        e.last = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(BW'(i), 0);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_pix_o_valid", int'(pix_o_valid), 0);
        checkOutput("midreset_pix_o", int'(pix_o), 0);
        checkOutput("midreset_pix_o_last", int'(pix_o_last), 0);
        checkOutput("midreset_pix_i_ready", int'(pix_i_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pushExpect(exp_asc);
        sendFrame(0, 0);

        // Two frames back to back with random valid gaps.
        $display("[TB] back-to-back frames with gaps");
        pushExpect(exp_asc);
        pushExpect(exp_desc);
        sendFrame(0, 2);
        sendFrame(1, 2);

        // Wait until every queued result has been seen.
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
